// File: rtl/mini_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mini_cpu_pkg
// Description : Shared definitions for the Mini-CPU controller: data widths,
//               opcodes, instruction field positions, FSM state encoding and
//               small field-extraction helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mini_cpu_pkg;

    localparam int DATA_W   = 16;
    localparam int INSTR_W  = 16;
    localparam int NUM_REGS = 8;
    localparam int REG_AW   = 3;
    localparam int OPC_W    = 3;
    localparam int IMM_W    = 6;
    localparam int CNT_W    = 2;   // holds ALU_LAT-1 for ALU_LAT up to 4

    // Opcodes
    localparam logic [OPC_W-1:0] OP_LOAD    = 3'b000;
    localparam logic [OPC_W-1:0] OP_ADD     = 3'b001;
    localparam logic [OPC_W-1:0] OP_ADDI    = 3'b010;
    localparam logic [OPC_W-1:0] OP_SUB     = 3'b011;
    localparam logic [OPC_W-1:0] OP_SUBI    = 3'b100;
    localparam logic [OPC_W-1:0] OP_MUL     = 3'b101;
    localparam logic [OPC_W-1:0] OP_CLEAR   = 3'b110;
    localparam logic [OPC_W-1:0] OP_DISPLAY = 3'b111;

    // Instruction field bit positions
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 13;
    localparam int RD_MSB   = 12;
    localparam int RD_LSB   = 10;
    localparam int RS1_MSB  = 9;
    localparam int RS1_LSB  = 7;
    localparam int RS2_MSB  = 6;
    localparam int RS2_LSB  = 4;
    localparam int SIGN_BIT = 6;
    localparam int IMM_MSB  = 5;
    localparam int IMM_LSB  = 0;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ISSUE = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_DISP  = 3'd4;

    function automatic logic [OPC_W-1:0] f_opcode(input logic [INSTR_W-1:0] i);
        return i[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [REG_AW-1:0] f_rd(input logic [INSTR_W-1:0] i);
        return i[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [REG_AW-1:0] f_rs1(input logic [INSTR_W-1:0] i);
        return i[RS1_MSB:RS1_LSB];
    endfunction

    function automatic logic [REG_AW-1:0] f_rs2(input logic [INSTR_W-1:0] i);
        return i[RS2_MSB:RS2_LSB];
    endfunction

    function automatic logic f_sign(input logic [INSTR_W-1:0] i);
        return i[SIGN_BIT];
    endfunction

    function automatic logic [IMM_W-1:0] f_imm(input logic [INSTR_W-1:0] i);
        return i[IMM_MSB:IMM_LSB];
    endfunction

endpackage : mini_cpu_pkg
`default_nettype wire

// File: rtl/mini_cpu_if.sv
`default_nettype none
// ============================================================================
// Module      : mini_cpu_if
// Description : Instruction handshake, ALU and display bus of the Mini-CPU
//               controller. 'slave' is the controller view, 'master' is the
//               view of the surrounding instruction source / ALU / display.
// Revision    : 1.0 - initial release
// ============================================================================
interface mini_cpu_if;
    import mini_cpu_pkg::*;

    logic                instr_valid;
    logic [INSTR_W-1:0]  instr;
    logic                instr_ready;
    logic [OPC_W-1:0]    alu_opcode;
    logic [DATA_W-1:0]   alu_valor1;
    logic [DATA_W-1:0]   alu_valor2;
    logic                alu_sinal_imm;
    logic [IMM_W-1:0]    alu_imm;
    logic [DATA_W-1:0]   alu_saida;
    logic                busy;
    logic                done;
    logic                disp_valid;
    logic [DATA_W-1:0]   disp_data;

    modport master (
        output instr_valid, instr, alu_saida,
        input  instr_ready, alu_opcode, alu_valor1, alu_valor2, alu_sinal_imm,
               alu_imm, busy, done, disp_valid, disp_data
    );

    modport slave (
        input  instr_valid, instr, alu_saida,
        output instr_ready, alu_opcode, alu_valor1, alu_valor2, alu_sinal_imm,
               alu_imm, busy, done, disp_valid, disp_data
    );

endinterface : mini_cpu_if
`default_nettype wire

// File: rtl/mini_cpu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : mini_cpu_regfile
// Description : 8x16 register file, two combinational read ports, one
//               synchronous write port, asynchronous clear on rst_n.
//               No hard-wired zero register.
// Revision    : 1.0 - initial release
// ============================================================================
module mini_cpu_regfile
    import mini_cpu_pkg::*;
(
    input  wire                 clk,
    input  wire                 rst_n,
    input  wire  [REG_AW-1:0]   ra_addr,
    output logic [DATA_W-1:0]   ra_data,
    input  wire  [REG_AW-1:0]   rb_addr,
    output logic [DATA_W-1:0]   rb_data,
    input  wire                 we,
    input  wire  [REG_AW-1:0]   wa_addr,
    input  wire  [DATA_W-1:0]   wa_data
);

    logic [NUM_REGS-1:0][DATA_W-1:0] mem_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] mem_d;

    // Next register contents: single write port
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[wa_addr] = wa_data;
        end
    end

    // Register storage with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Combinational read ports
    always_comb begin
        ra_data = mem_q[ra_addr];
        rb_data = mem_q[rb_addr];
    end

endmodule : mini_cpu_regfile
`default_nettype wire

// File: rtl/mini_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : mini_cpu_controller
// Description : Mini-CPU sequencer. Accepts 16-bit instructions over a
//               valid/ready handshake, reads operands from the register file,
//               holds the ALU inputs for ALU_LAT edges, writes the ALU result
//               back and pulses done. DISPLAY bypasses the ALU.
//               Optional feature macro: MINI_CPU_QUEUE_EN adds a 2-entry
//               instruction FIFO in front of the FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module mini_cpu_controller
    import mini_cpu_pkg::*;
#(
    parameter int ALU_LAT = 2   // legal 1..4
)
(
    input  wire       clk,
    input  wire       rst_n,
    mini_cpu_if.slave bus
);

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [DATA_W-1:0]    disp_q,  disp_d;

    logic                 w_take;        // FSM latches w_next_instr this cycle
    logic [INSTR_W-1:0]   w_next_instr;
    logic                 w_ready;
    logic [DATA_W-1:0]    w_rd_a;
    logic [DATA_W-1:0]    w_rd_b;
    logic                 w_we;
    logic                 w_alu_act;

`ifdef MINI_CPU_QUEUE_EN
    logic [1:0][INSTR_W-1:0] fifo_q, fifo_d;
    logic                    fifo_wp_q, fifo_wp_d;
    logic                    fifo_rp_q, fifo_rp_d;
    logic [1:0]              fifo_cnt_q, fifo_cnt_d;
    logic                    w_push;
    logic                    w_full;

    // FIFO control: the FSM pops the head whenever it is about to become
    // free (IDLE, or the last cycle of WRITE/DISP), removing the IDLE bubble
    always_comb begin
        w_full       = (fifo_cnt_q == 2'd2);
        w_ready      = !w_full;
        w_push       = bus.instr_valid && !w_full;
        w_take       = (fifo_cnt_q != 2'd0) &&
                       ((state_q == ST_IDLE) || (state_q == ST_WRITE) ||
                        (state_q == ST_DISP));
        w_next_instr = fifo_q[fifo_rp_q];
        fifo_d       = fifo_q;
        fifo_wp_d    = fifo_wp_q;
        fifo_rp_d    = fifo_rp_q;
        if (w_push) begin
            fifo_d[fifo_wp_q] = bus.instr;
            fifo_wp_d         = ~fifo_wp_q;
        end
        if (w_take) begin
            fifo_rp_d = ~fifo_rp_q;
        end
        fifo_cnt_d = fifo_cnt_q + {1'b0, w_push} - {1'b0, w_take};
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q     <= '0;
            fifo_wp_q  <= 1'b0;
            fifo_rp_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            fifo_q     <= fifo_d;
            fifo_wp_q  <= fifo_wp_d;
            fifo_rp_q  <= fifo_rp_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end
`else
    // Direct handshake: an instruction is taken only while IDLE
    always_comb begin
        w_ready      = (state_q == ST_IDLE);
        w_take       = bus.instr_valid && (state_q == ST_IDLE);
        w_next_instr = bus.instr;
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_WRITE, ST_DISP: begin
                if (w_take) begin
                    state_d = (f_opcode(w_next_instr) == OP_DISPLAY) ? ST_DISP : ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = (ALU_LAT == 1) ? ST_WRITE : ST_WAIT;
            ST_WAIT: begin
                // counter reaches zero on this edge -> result valid next cycle
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_WRITE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: instruction latch, wait counter, display hold
    always_comb begin
        instr_d = w_take ? w_next_instr : instr_q;
        cnt_d   = cnt_q;
        if (state_q == ST_ISSUE) begin
            cnt_d = CNT_W'(ALU_LAT - 1);
        end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        disp_d = (state_q == ST_DISP) ? w_rd_a : disp_q;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
        end else begin
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
        end
    end

    // FSM outputs: ALU inputs are held from ISSUE through WRITE; operands are
    // read combinationally and only change after the WRITE edge
    always_comb begin
        w_alu_act = (state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                    (state_q == ST_WRITE);
        bus.alu_opcode    = OP_CLEAR;
        bus.alu_valor1    = '0;
        bus.alu_valor2    = '0;
        bus.alu_sinal_imm = 1'b0;
        bus.alu_imm       = '0;
        if (w_alu_act) begin
            bus.alu_opcode    = f_opcode(instr_q);
            bus.alu_valor1    = w_rd_a;
            bus.alu_valor2    = w_rd_b;
            bus.alu_sinal_imm = f_sign(instr_q);
            bus.alu_imm       = f_imm(instr_q);
        end
        bus.instr_ready = w_ready;
        bus.busy        = (state_q != ST_IDLE);
        bus.done        = (state_q == ST_WRITE) || (state_q == ST_DISP);
        bus.disp_valid  = (state_q == ST_DISP);
        bus.disp_data   = (state_q == ST_DISP) ? w_rd_a : disp_q;
        w_we            = (state_q == ST_WRITE);
    end

    mini_cpu_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (f_rs1(instr_q)),
        .ra_data (w_rd_a),
        .rb_addr (f_rs2(instr_q)),
        .rb_data (w_rd_b),
        .we      (w_we),
        .wa_addr (f_rd(instr_q)),
        .wa_data (bus.alu_saida)
    );

endmodule : mini_cpu_controller
`default_nettype wire

// File: tb/tb_mini_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mini_cpu_controller
// Description : Directed self-checking bench for mini_cpu_controller with a
//               behavioural registered ALU of latency ALU_LAT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mini_cpu_controller;
    import mini_cpu_pkg::*;

    localparam int ALU_LAT = 2;
`ifdef MINI_CPU_QUEUE_EN
    localparam int XQ = 1;       // FIFO adds one IDLE pop cycle to a lone instruction
`else
    localparam int XQ = 0;
`endif
    localparam int LAT_ALU  = ALU_LAT + 1 + XQ;
    localparam int LAT_DISP = 1 + XQ;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    mini_cpu_if bus();

    mini_cpu_controller #(.ALU_LAT(ALU_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: combinational result delayed by ALU_LAT edges
    function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic s,
                                          input logic [5:0] imm);
        logic [15:0] si;
        si = s ? (16'd0 - {10'd0, imm}) : {10'd0, imm};
        case (op)
            OP_LOAD: return si;
            OP_ADD:  return a + b;
            OP_ADDI: return a + si;
            OP_SUB:  return a - b;
            OP_SUBI: return a - si;
            OP_MUL:  return a * si;
            default: return 16'd0;
        endcase
    endfunction

    logic [15:0] alu_pipe [ALU_LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_f(bus.alu_opcode, bus.alu_valor1, bus.alu_valor2,
                             bus.alu_sinal_imm, bus.alu_imm);
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign bus.alu_saida = alu_pipe[ALU_LAT-1];

    function automatic logic [15:0] mk_r(input logic [2:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 4'b0000};
    endfunction

    function automatic logic [15:0] mk_i(input logic [2:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs1, input logic s,
                                         input logic [5:0] imm);
        return {op, rd, rs1, s, imm};
    endfunction

    function automatic logic [15:0] mk_disp(input logic [2:0] rs);
        return {OP_DISPLAY, 3'd0, rs, 7'd0};
    endfunction

    // Present one instruction, wait for done (bounded), step to the next
    // cycle. lat = cycles from accept edge to done, -1 on timeout.
    task automatic send(input logic [15:0] ins, output int lat, output logic dv,
                        output logic [15:0] dd);
        int n;
        lat = -1; dv = 1'b0; dd = '0; n = 0;
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        while (bus.instr_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        if (n < 20) begin
            for (int c = 1; c <= 20; c++) begin
                if (bus.done === 1'b1) begin
                    lat = c; dv = bus.disp_valid; dd = bus.disp_data;
                    break;
                end
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.instr_valid = 1'b0; bus.instr = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.instr_ready); end
        total++; if (bus.alu_opcode !== 3'b110) begin bad++; $display("FAIL reset_opcode: got %b want 110", bus.alu_opcode); end
        total++; if ({bus.alu_valor1, bus.alu_valor2} !== 32'd0) begin bad++; $display("FAIL reset_valor: got %h want 0", {bus.alu_valor1, bus.alu_valor2}); end
        total++; if ({bus.alu_sinal_imm, bus.alu_imm} !== 7'd0) begin bad++; $display("FAIL reset_imm: got %h want 0", {bus.alu_sinal_imm, bus.alu_imm}); end
        total++; if ({bus.done, bus.disp_valid, bus.busy} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {bus.done, bus.disp_valid, bus.busy}); end
        total++; if (bus.disp_data !== 16'd0) begin bad++; $display("FAIL reset_disp_data: got %h want 0000", bus.disp_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if ({bus.instr_ready, bus.busy} !== 2'b10) begin bad++; $display("FAIL post_reset_ready_busy: got %b want 10", {bus.instr_ready, bus.busy}); end
    endtask

    task automatic test_load_display();
        int lat; logic dv; logic [15:0] dd;
        send(mk_i(OP_LOAD, 3'd1, 3'd0, 1'b0, 6'd5), lat, dv, dd);
        total++; if (lat !== LAT_ALU) begin bad++; $display("FAIL load_latency: got %0d want %0d", lat, LAT_ALU); end
        send(mk_disp(3'd1), lat, dv, dd);
        total++; if (lat !== LAT_DISP) begin bad++; $display("FAIL disp_latency: got %0d want %0d", lat, LAT_DISP); end
        total++; if (dv !== 1'b1) begin bad++; $display("FAIL disp_valid_pulse: got %b want 1", dv); end
        total++; if (dd !== 16'h0005) begin bad++; $display("FAIL disp_r1: got %h want 0005", dd); end
        total++; if (bus.disp_valid !== 1'b0) begin bad++; $display("FAIL disp_valid_one_cycle: got %b want 0", bus.disp_valid); end
        total++; if (bus.disp_data !== 16'h0005) begin bad++; $display("FAIL disp_data_hold: got %h want 0005", bus.disp_data); end
    endtask

    task automatic test_add_sub();
        int lat; logic dv; logic [15:0] dd;
        send(mk_i(OP_LOAD, 3'd2, 3'd0, 1'b0, 6'd3), lat, dv, dd);
        // ADD r3,r1,r2 stepped cycle by cycle
        bus.instr = mk_r(OP_ADD, 3'd3, 3'd1, 3'd2);
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        repeat (XQ) begin @(posedge clk); #1; end
        total++; if ({bus.busy, bus.instr_ready} !== {1'b1, XQ == 1}) begin bad++; $display("FAIL issue_busy_ready: got %b", {bus.busy, bus.instr_ready}); end
        total++; if (bus.alu_opcode !== OP_ADD) begin bad++; $display("FAIL issue_opcode: got %b want 001", bus.alu_opcode); end
        total++; if ({bus.alu_valor1, bus.alu_valor2} !== {16'h0005, 16'h0003}) begin bad++; $display("FAIL issue_operands: got %h want 00050003", {bus.alu_valor1, bus.alu_valor2}); end
        total++; if ({bus.alu_sinal_imm, bus.alu_imm} !== 7'b0100000) begin bad++; $display("FAIL issue_imm_bits: got %b want 0100000", {bus.alu_sinal_imm, bus.alu_imm}); end
        @(posedge clk); #1;
        total++; if ({bus.done, bus.alu_valor1} !== {1'b0, 16'h0005}) begin bad++; $display("FAIL wait_hold: got %h want 00005", {bus.done, bus.alu_valor1}); end
        @(posedge clk); #1;
        total++; if ({bus.done, bus.alu_opcode} !== {1'b1, OP_ADD}) begin bad++; $display("FAIL write_done: got %b want 1001", {bus.done, bus.alu_opcode}); end
        @(posedge clk); #1;
        total++; if ({bus.done, bus.alu_opcode, bus.busy} !== {1'b0, OP_CLEAR, 1'b0}) begin bad++; $display("FAIL back_idle: got %b want 01100", {bus.done, bus.alu_opcode, bus.busy}); end
        send(mk_r(OP_SUB, 3'd4, 3'd2, 3'd1), lat, dv, dd);
        send(mk_disp(3'd3), lat, dv, dd);
        total++; if (dd !== 16'h0008) begin bad++; $display("FAIL add_r3: got %h want 0008", dd); end
        send(mk_disp(3'd4), lat, dv, dd);
        total++; if (dd !== 16'hFFFE) begin bad++; $display("FAIL sub_r4: got %h want fffe", dd); end
    endtask

    task automatic test_reset_mid();
        int lat; logic dv; logic [15:0] dd; logic saw;
        bus.instr = mk_r(OP_ADD, 3'd3, 3'd1, 3'd2);
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        repeat (XQ) begin @(posedge clk); #1; end
        @(posedge clk); #1;            // now in WAIT
        rst_n = 1'b0;
        #1;
        total++; if ({bus.busy, bus.instr_ready, bus.done} !== 3'b010) begin bad++; $display("FAIL async_reset_flags: got %b want 010", {bus.busy, bus.instr_ready, bus.done}); end
        saw = 1'b0;
        for (int c = 0; c < 3; c++) begin @(posedge clk); #1; saw |= bus.done; end
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin @(posedge clk); #1; saw |= bus.done; end
        total++; if (saw !== 1'b0) begin bad++; $display("FAIL reset_no_done: got %b want 0", saw); end
        total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after: got %b want 1", bus.instr_ready); end
        send(mk_disp(3'd3), lat, dv, dd);
        total++; if (dd !== 16'h0000) begin bad++; $display("FAIL reset_r3_clear: got %h want 0000", dd); end
        send(mk_disp(3'd1), lat, dv, dd);
        total++; if (dd !== 16'h0000) begin bad++; $display("FAIL reset_r1_clear: got %h want 0000", dd); end
    endtask

    task automatic test_imm();
        int lat; logic dv; logic [15:0] dd;
        send(mk_i(OP_LOAD, 3'd1, 3'd0, 1'b0, 6'd10), lat, dv, dd);
        send(mk_i(OP_ADDI, 3'd5, 3'd1, 1'b1, 6'd4), lat, dv, dd);
        send(mk_i(OP_SUBI, 3'd6, 3'd1, 1'b1, 6'd4), lat, dv, dd);
        send(mk_disp(3'd5), lat, dv, dd);
        total++; if (dd !== 16'h0006) begin bad++; $display("FAIL addi_r5: got %h want 0006", dd); end
        send(mk_disp(3'd6), lat, dv, dd);
        total++; if (dd !== 16'h000E) begin bad++; $display("FAIL subi_r6: got %h want 000e", dd); end
        send(mk_i(OP_LOAD, 3'd2, 3'd0, 1'b1, 6'd1), lat, dv, dd);
        send(mk_disp(3'd2), lat, dv, dd);
        total++; if (dd !== 16'hFFFF) begin bad++; $display("FAIL load_neg_r2: got %h want ffff", dd); end
    endtask

    task automatic test_mul_clear();
        int lat; logic dv; logic [15:0] dd;
        send(mk_i(OP_LOAD, 3'd1, 3'd0, 1'b0, 6'd32), lat, dv, dd);
        send(mk_i(OP_MUL, 3'd1, 3'd1, 1'b0, 6'd32), lat, dv, dd);   // rd == rs1
        send(mk_i(OP_MUL, 3'd1, 3'd1, 1'b0, 6'd16), lat, dv, dd);
        send(mk_disp(3'd1), lat, dv, dd);
        total++; if (dd !== 16'h4000) begin bad++; $display("FAIL mul_r1: got %h want 4000", dd); end
        send(mk_i(OP_LOAD, 3'd7, 3'd0, 1'b0, 6'd1), lat, dv, dd);
        send(mk_i(OP_MUL, 3'd7, 3'd1, 1'b0, 6'd8), lat, dv, dd);
        send(mk_disp(3'd7), lat, dv, dd);
        total++; if (dd !== 16'h0000) begin bad++; $display("FAIL mul_wrap_r7: got %h want 0000", dd); end
        send(mk_i(OP_LOAD, 3'd7, 3'd0, 1'b0, 6'd5), lat, dv, dd);
        send(mk_r(OP_CLEAR, 3'd7, 3'd0, 3'd0), lat, dv, dd);
        total++; if (lat !== LAT_ALU) begin bad++; $display("FAIL clear_latency: got %0d want %0d", lat, LAT_ALU); end
        send(mk_disp(3'd7), lat, dv, dd);
        total++; if (dd !== 16'h0000) begin bad++; $display("FAIL clear_r7: got %h want 0000", dd); end
    endtask

    task automatic test_back_to_back();
        int lat; logic dv; logic [15:0] dd;
        logic [15:0] prog [3];
        int idx, nd, stall;
        int dn [3];
        logic acc;
        prog[0] = mk_i(OP_LOAD, 3'd1, 3'd0, 1'b0, 6'd7);
        prog[1] = mk_i(OP_LOAD, 3'd2, 3'd0, 1'b0, 6'd9);
        prog[2] = mk_i(OP_LOAD, 3'd3, 3'd0, 1'b0, 6'd11);
        idx = 0; nd = 0; stall = 0;
        dn[0] = -1; dn[1] = -1; dn[2] = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.done === 1'b1 && nd < 3) begin dn[nd] = cyc; nd++; end
            bus.instr_valid = (idx < 3);
            bus.instr = (idx < 3) ? prog[idx] : 16'h0000;
            acc = bus.instr_valid && bus.instr_ready;
            if (bus.instr_valid && !bus.instr_ready) stall++;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        bus.instr_valid = 1'b0;
        total++; if (nd !== 3) begin bad++; $display("FAIL b2b_done_count: got %0d want 3", nd); end
        total++; if (dn[0] !== ALU_LAT + 1 + XQ) begin bad++; $display("FAIL b2b_first_done: got %0d want %0d", dn[0], ALU_LAT + 1 + XQ); end
`ifdef MINI_CPU_QUEUE_EN
        total++; if ((dn[1] - dn[0]) !== 3 || (dn[2] - dn[1]) !== 3) begin bad++; $display("FAIL b2b_spacing: got %0d,%0d want 3,3", dn[1] - dn[0], dn[2] - dn[1]); end
        total++; if (stall > 1) begin bad++; $display("FAIL b2b_stall: got %0d want <=1", stall); end
`else
        total++; if ((dn[1] - dn[0]) !== 4 || (dn[2] - dn[1]) !== 4) begin bad++; $display("FAIL b2b_spacing: got %0d,%0d want 4,4", dn[1] - dn[0], dn[2] - dn[1]); end
        total++; if (stall !== 6) begin bad++; $display("FAIL b2b_stall: got %0d want 6", stall); end
`endif
        send(mk_disp(3'd2), lat, dv, dd);
        total++; if (dd !== 16'h0009) begin bad++; $display("FAIL b2b_r2: got %h want 0009", dd); end
        send(mk_disp(3'd3), lat, dv, dd);
        total++; if (dd !== 16'h000B) begin bad++; $display("FAIL b2b_r3: got %h want 000b", dd); end
    endtask

    initial begin
        test_reset();
        test_load_display();
        test_add_sub();
        test_reset_mid();
        test_imm();
        test_mul_clear();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_mini_cpu_controller
`default_nettype wire
